// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide HCI TCDM request into MP independent 32-bit bank requests and
// reassembles the per-bank responses into a single wide response.
module redmule_tcdm_splitter #(
    parameter int unsigned DW             = 256,
    parameter int unsigned MP             = DW / 32,
    parameter int unsigned NumOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wide_req_i,
    output logic                wide_gnt_o,
    input  logic [31:0]         wide_add_i,
    input  logic                wide_wen_i,
    input  logic [DW/8-1:0]     wide_be_i,
    input  logic [DW-1:0]       wide_data_i,
    output logic [DW-1:0]       wide_r_data_o,
    output logic                wide_r_valid_o,
    output logic                wide_r_opc_o,
    output logic [MP-1:0]       tcdm_req_o,
    input  logic [MP-1:0]       tcdm_gnt_i,
    output logic [MP-1:0][31:0] tcdm_add_o,
    output logic [MP-1:0]       tcdm_wen_o,
    output logic [MP-1:0][3:0]  tcdm_be_o,
    output logic [MP-1:0][31:0] tcdm_data_o,
    input  logic [MP-1:0][31:0] tcdm_r_data_i,
    input  logic [MP-1:0]       tcdm_r_valid_i,
    input  logic [MP-1:0]       tcdm_r_opc_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam int unsigned CW = $clog2(NumOutstanding + 1);
    localparam int unsigned PW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

    logic [MP-1:0]         gmask_q, gmask_d;
    logic [CW-1:0]         out_cnt_q, out_cnt_d;
    logic [MP-1:0][CW-1:0] pend_q, pend_d;
    logic [MP-1:0][CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [MP-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [MP-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic                  err_q, err_d;

    logic [31:0] fifo_data_q [MP][NumOutstanding];
    logic        fifo_opc_q  [MP][NumOutstanding];

    logic          credit_ok;
    logic [MP-1:0] narrow_gnt;
    logic [MP-1:0] accept;
    logic [MP-1:0] fifo_nempty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NumOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request fan-out: every narrow port sees its own slice of the wide request.
    always_comb begin
        tcdm_add_o  = '0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        for (int ii = 0; ii < MP; ii++) begin
            tcdm_add_o[ii]  = wide_add_i + 32'(4 * ii);
            tcdm_be_o[ii]   = wide_be_i[4*ii +: 4];
            tcdm_data_o[ii] = wide_data_i[32*ii +: 32];
        end
    end

    assign tcdm_wen_o = {MP{wide_wen_i}};
    assign credit_ok  = (out_cnt_q < CW'(NumOutstanding));
    assign tcdm_req_o = {MP{wide_req_i & credit_ok}} & ~gmask_q;
    assign narrow_gnt = tcdm_req_o & tcdm_gnt_i;
    assign wide_gnt_o = wide_req_i & credit_ok & (&(gmask_q | narrow_gnt));

    assign wide_r_valid_o = &fifo_nempty;
    assign busy_o         = (out_cnt_q != '0) | (|gmask_q);
    assign err_o          = err_q;

    // Response gather: data is forced to zero whenever no wide response is presented.
    always_comb begin
        wide_r_data_o = '0;
        wide_r_opc_o  = 1'b0;
        for (int ii = 0; ii < MP; ii++) begin
            if (wide_r_valid_o) begin
                wide_r_data_o[32*ii +: 32] = fifo_data_q[ii][rd_ptr_q[ii]];
                wide_r_opc_o               = wide_r_opc_o | fifo_opc_q[ii][rd_ptr_q[ii]];
            end
        end
    end

    // NOTE: every signal driven in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gmask_d     = wide_gnt_o ? '0 : (gmask_q | narrow_gnt);
        out_cnt_d   = out_cnt_q;
        pend_d      = pend_q;
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        accept      = '0;
        fifo_nempty = '0;
        err_d       = err_q;

        if (wide_gnt_o && !wide_r_valid_o) out_cnt_d = out_cnt_q + 1'b1;
        else if (!wide_gnt_o && wide_r_valid_o) out_cnt_d = out_cnt_q - 1'b1;

        for (int ii = 0; ii < MP; ii++) begin
            fifo_nempty[ii] = (fifo_cnt_q[ii] != '0);
            accept[ii]      = tcdm_r_valid_i[ii] & (pend_q[ii] != '0);
            if (tcdm_r_valid_i[ii] && !accept[ii]) err_d = 1'b1;

            if (narrow_gnt[ii] && !accept[ii]) pend_d[ii] = pend_q[ii] + 1'b1;
            else if (!narrow_gnt[ii] && accept[ii]) pend_d[ii] = pend_q[ii] - 1'b1;

            if (accept[ii]) wr_ptr_d[ii] = ptr_inc(wr_ptr_q[ii]);
            if (wide_r_valid_o) rd_ptr_d[ii] = ptr_inc(rd_ptr_q[ii]);
            fifo_cnt_d[ii] = fifo_cnt_q[ii] + CW'(accept[ii]) - CW'(wide_r_valid_o);
        end
    end

    // NOTE: control state uses non-blocking assignments and a synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gmask_q    <= '0;
            out_cnt_q  <= '0;
            pend_q     <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            gmask_q    <= gmask_d;
            out_cnt_q  <= out_cnt_d;
            pend_q     <= pend_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // NOTE: FIFO storage is not reset; clearing the counts and pointers empties the FIFOs.
    always_ff @(posedge clk_i) begin
        for (int ii = 0; ii < MP; ii++) begin
            if (accept[ii]) begin
                fifo_data_q[ii][wr_ptr_q[ii]] <= tcdm_r_data_i[ii];
                fifo_opc_q[ii][wr_ptr_q[ii]]  <= tcdm_r_opc_i[ii];
            end
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed bench for redmule_tcdm_splitter: a queue-based model is checked every cycle,
// and literal expectations pin the main scenarios.
module tb_redmule_tcdm_splitter;

    localparam int DW = 256;
    localparam int MP = 8;
    localparam int NO = 2;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                wide_req_i;
    logic                wide_gnt_o;
    logic [31:0]         wide_add_i;
    logic                wide_wen_i;
    logic [DW/8-1:0]     wide_be_i;
    logic [DW-1:0]       wide_data_i;
    logic [DW-1:0]       wide_r_data_o;
    logic                wide_r_valid_o;
    logic                wide_r_opc_o;
    logic [MP-1:0]       tcdm_req_o;
    logic [MP-1:0]       tcdm_gnt_i;
    logic [MP-1:0][31:0] tcdm_add_o;
    logic [MP-1:0]       tcdm_wen_o;
    logic [MP-1:0][3:0]  tcdm_be_o;
    logic [MP-1:0][31:0] tcdm_data_o;
    logic [MP-1:0][31:0] tcdm_r_data_i;
    logic [MP-1:0]       tcdm_r_valid_i;
    logic [MP-1:0]       tcdm_r_opc_i;
    logic                busy_o;
    logic                err_o;

    redmule_tcdm_splitter #(.DW(DW), .MP(MP), .NumOutstanding(NO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wide_req_i(wide_req_i), .wide_gnt_o(wide_gnt_o), .wide_add_i(wide_add_i),
        .wide_wen_i(wide_wen_i), .wide_be_i(wide_be_i), .wide_data_i(wide_data_i),
        .wide_r_data_o(wide_r_data_o), .wide_r_valid_o(wide_r_valid_o), .wide_r_opc_o(wide_r_opc_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_opc_i(tcdm_r_opc_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run = 1'b0;
    bit [MP-1:0] m_granted = '0;
    int          m_out = 0;
    int          m_pend [MP];
    bit          m_err = 1'b0;
    logic [32:0] m_rq [MP][$];

    initial for (int ii = 0; ii < MP; ii++) m_pend[ii] = 0;

    always @(negedge clk_i) begin
        bit            credit;
        bit            all_done;
        logic [MP-1:0] e_req, e_ng;
        logic          e_wgnt, e_rv, e_opc;
        logic [DW-1:0] e_data, e_add;
        if (m_run) begin
            credit = (m_out < NO);
            e_rv   = 1'b1;
            for (int ii = 0; ii < MP; ii++) if (m_rq[ii].size() == 0) e_rv = 1'b0;
            e_data = '0;
            e_opc  = 1'b0;
            if (e_rv) begin
                for (int ii = 0; ii < MP; ii++) begin
                    e_data[32*ii +: 32] = m_rq[ii][0][31:0];
                    e_opc = e_opc | m_rq[ii][0][32];
                end
            end
            for (int ii = 0; ii < MP; ii++) e_req[ii] = wide_req_i && credit && !m_granted[ii];
            e_ng     = e_req & tcdm_gnt_i;
            all_done = 1'b1;
            for (int ii = 0; ii < MP; ii++) if (!(m_granted[ii] || e_ng[ii])) all_done = 1'b0;
            e_wgnt = wide_req_i && credit && all_done;

            check("model tcdm_req", DW'(tcdm_req_o), DW'(e_req));
            check("model wide_gnt", DW'(wide_gnt_o), DW'(e_wgnt));
            check("model wide_r_valid", DW'(wide_r_valid_o), DW'(e_rv));
            check("model busy", DW'(busy_o), DW'((m_out != 0) || (m_granted != '0)));
            check("model err", DW'(err_o), DW'(m_err));
            if (e_rv) begin
                check("model wide_r_data", wide_r_data_o, e_data);
                check("model wide_r_opc", DW'(wide_r_opc_o), DW'(e_opc));
            end
            if (wide_req_i) begin
                for (int ii = 0; ii < MP; ii++) e_add[32*ii +: 32] = wide_add_i + 32'(4 * ii);
                check("model tcdm_add", DW'(tcdm_add_o), e_add);
                check("model tcdm_wen", DW'(tcdm_wen_o), DW'({MP{wide_wen_i}}));
                check("model tcdm_be", DW'(tcdm_be_o), DW'(wide_be_i));
                check("model tcdm_data", DW'(tcdm_data_o), wide_data_i);
            end

            // State advance as seen at the following rising edge.
            if (rst_i) begin
                m_granted = '0;
                m_out     = 0;
                m_err     = 1'b0;
                for (int ii = 0; ii < MP; ii++) begin
                    m_pend[ii] = 0;
                    m_rq[ii].delete();
                end
            end else begin
                if (e_rv) for (int ii = 0; ii < MP; ii++) void'(m_rq[ii].pop_front());
                for (int ii = 0; ii < MP; ii++) begin
                    if (tcdm_r_valid_i[ii]) begin
                        if (m_pend[ii] > 0) begin
                            m_rq[ii].push_back({tcdm_r_opc_i[ii], tcdm_r_data_i[ii]});
                            m_pend[ii]--;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    if (e_ng[ii]) m_pend[ii]++;
                end
                m_granted = e_wgnt ? '0 : (m_granted | e_ng);
                m_out     = m_out + int'(e_wgnt) - int'(e_rv);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic set_resp(input logic [MP-1:0] vld, input logic [15:0] tag, input logic [MP-1:0] opc);
        tcdm_r_valid_i = vld;
        tcdm_r_opc_i   = opc;
        for (int ii = 0; ii < MP; ii++) tcdm_r_data_i[ii] = {tag, 16'(ii)};
    endtask

    initial begin
        rst_i          = 1'b1;
        wide_req_i     = 1'b0;
        wide_add_i     = '0;
        wide_wen_i     = 1'b1;
        wide_be_i      = '1;
        wide_data_i    = '0;
        tcdm_gnt_i     = '1;
        tcdm_r_data_i  = '0;
        tcdm_r_valid_i = '0;
        tcdm_r_opc_i   = '0;
        step();
        m_run = 1'b1;
        step();
        rst_i = 1'b0;

        // Reset state
        mid();
        check("reset busy", DW'(busy_o), '0);
        check("reset err", DW'(err_o), '0);
        check("reset r_valid", DW'(wide_r_valid_o), '0);
        check("reset r_data", wide_r_data_o, '0);
        check("reset r_opc", DW'(wide_r_opc_o), '0);
        check("reset tcdm_req", DW'(tcdm_req_o), '0);
        step();

        // Single read, all banks grant immediately
        wide_req_i  = 1'b1;
        wide_wen_i  = 1'b1;
        wide_add_i  = 32'h1000_0000;
        wide_data_i = {8{32'h1234_5678}};
        mid();
        check("rd wide_gnt", DW'(wide_gnt_o), DW'(1));
        check("rd add7", DW'(tcdm_add_o[7]), DW'(32'h1000_001C));
        check("rd tcdm_req", DW'(tcdm_req_o), DW'(8'hFF));
        step();
        wide_req_i = 1'b0;
        set_resp('1, 16'hC0DE, '0);
        mid();
        check("rd r_valid early", DW'(wide_r_valid_o), '0);
        step();
        set_resp('0, 16'h0, '0);
        mid();
        check("rd r_valid", DW'(wide_r_valid_o), DW'(1));
        check("rd r_data", wide_r_data_o,
              256'hC0DE0007_C0DE0006_C0DE0005_C0DE0004_C0DE0003_C0DE0002_C0DE0001_C0DE0000);
        step();
        mid();
        check("rd r_valid one cycle", DW'(wide_r_valid_o), '0);
        check("rd idle busy", DW'(busy_o), '0);
        step();

        // Port 3 grant delayed, then skewed write responses
        wide_req_i  = 1'b1;
        wide_wen_i  = 1'b0;
        wide_add_i  = 32'h2000_0040;
        wide_data_i = {8{32'hCAFE_F00D}};
        tcdm_gnt_i  = 8'hF7;
        mid();
        check("dly c1 req", DW'(tcdm_req_o), DW'(8'hFF));
        check("dly c1 gnt", DW'(wide_gnt_o), '0);
        for (int c = 2; c <= 3; c++) begin
            step();
            mid();
            check("dly mid req", DW'(tcdm_req_o), DW'(8'h08));
            check("dly mid gnt", DW'(wide_gnt_o), '0);
        end
        step();
        tcdm_gnt_i = '1;
        mid();
        check("dly c4 req", DW'(tcdm_req_o), DW'(8'h08));
        check("dly c4 gnt", DW'(wide_gnt_o), DW'(1));
        step();
        wide_req_i = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            set_resp((k < 5) ? MP'(1 << k) : MP'(8'hE0), 16'hBEEF, 8'h20);
            mid();
            check("skew no r_valid", DW'(wide_r_valid_o), '0);
            step();
        end
        set_resp('0, 16'h0, '0);
        mid();
        check("skew r_valid", DW'(wide_r_valid_o), DW'(1));
        check("skew r_opc", DW'(wide_r_opc_o), DW'(1));
        check("skew r_data", wide_r_data_o,
              256'hBEEF0007_BEEF0006_BEEF0005_BEEF0004_BEEF0003_BEEF0002_BEEF0001_BEEF0000);
        step();
        mid();
        check("skew r_valid one cycle", DW'(wide_r_valid_o), '0);
        step();

        // Credit limit: three requests, responses withheld
        wide_req_i = 1'b1;
        wide_wen_i = 1'b1;
        wide_add_i = 32'h3000_0000;
        mid();
        check("cred g1", DW'(wide_gnt_o), DW'(1));
        step();
        wide_add_i = 32'h3000_0020;
        mid();
        check("cred g2", DW'(wide_gnt_o), DW'(1));
        step();
        wide_add_i = 32'h3000_0040;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("cred full req", DW'(tcdm_req_o), '0);
            check("cred full gnt", DW'(wide_gnt_o), '0);
            check("cred full busy", DW'(busy_o), DW'(1));
            step();
        end
        set_resp('1, 16'h3000, '0);
        mid();
        step();
        set_resp('1, 16'h3001, '0);
        mid();
        check("cred resp0 valid", DW'(wide_r_valid_o), DW'(1));
        check("cred same-cycle req", DW'(tcdm_req_o), '0);
        step();
        set_resp('0, 16'h0, '0);
        mid();
        check("cred freed req", DW'(tcdm_req_o), DW'(8'hFF));
        check("cred g3", DW'(wide_gnt_o), DW'(1));
        step();
        wide_req_i = 1'b0;
        set_resp('1, 16'h3002, '0);
        mid();
        step();
        set_resp('0, 16'h0, '0);
        mid();
        check("cred last valid", DW'(wide_r_valid_o), DW'(1));
        step();
        mid();
        check("cred drained busy", DW'(busy_o), '0);
        step();

        // Unsolicited response on port 2
        set_resp(8'h04, 16'hBAD0, '0);
        mid();
        check("unsol err before", DW'(err_o), '0);
        step();
        set_resp('0, 16'h0, '0);
        for (int c = 0; c < 2; c++) begin
            mid();
            check("unsol err sticky", DW'(err_o), DW'(1));
            check("unsol no r_valid", DW'(wide_r_valid_o), '0);
            step();
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mid();
        check("unsol err cleared", DW'(err_o), '0);
        step();

        // Reset in the middle of a partially granted request
        wide_req_i = 1'b1;
        wide_add_i = 32'h5000_0000;
        tcdm_gnt_i = 8'hF7;
        mid();
        check("midrst gnt", DW'(wide_gnt_o), '0);
        step();
        wide_req_i = 1'b0;
        tcdm_gnt_i = '1;
        rst_i      = 1'b1;
        mid();
        check("midrst busy before", DW'(busy_o), DW'(1));
        step();
        rst_i = 1'b0;
        set_resp(8'hF7, 16'h5000, '0);
        mid();
        check("midrst busy after", DW'(busy_o), '0);
        step();
        set_resp('0, 16'h0, '0);
        mid();
        check("midrst late err", DW'(err_o), DW'(1));
        check("midrst no r_valid", DW'(wide_r_valid_o), '0);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;

        // Address wrap
        wide_req_i = 1'b1;
        wide_add_i = 32'hFFFF_FFF0;
        mid();
        check("wrap add4", DW'(tcdm_add_o[4]), '0);
        check("wrap add3", DW'(tcdm_add_o[3]), DW'(32'hFFFF_FFFC));
        check("wrap gnt", DW'(wide_gnt_o), DW'(1));
        step();
        wide_req_i = 1'b0;
        set_resp('1, 16'hA5A5, 8'h00);
        mid();
        step();
        set_resp('0, 16'h0, '0);
        mid();
        check("wrap r_valid", DW'(wide_r_valid_o), DW'(1));
        check("wrap r_opc", DW'(wide_r_opc_o), '0);
        step();
        mid();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/redmule_tcdm_splitter.md
# redmule_tcdm_splitter

Parametrised splitter between RedMulE's wide HCI TCDM master port and MP independent 32-bit TCDM banks. Each narrow port is granted and answered independently: per-port grant masking, per-port response buffering, and one wide response once every port has answered. Sits between redmule_top's TCDM interface and the cluster interconnect. Supports up to NumOutstanding wide transactions in flight.

## Interface
- DW, 256: wide data width in bits; multiple of 32.
- MP, DW/32: number of narrow 32-bit ports.
- NumOutstanding, 2: max wide transactions accepted but not yet answered; also per-port response FIFO depth; ≥1.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- wide_req_i  in  1  wide request.
- wide_gnt_o  out  1  wide grant.
- wide_add_i  in  32  byte address of port 0 word.
- wide_wen_i  in  1  1 = read, 0 = write (TCDM convention).
- wide_be_i  in  DW/8  byte enables.
- wide_data_i  in  DW  write data.
- wide_r_data_o  out  DW  read data; port ii in bits [32ii+31:32ii].
- wide_r_valid_o  out  1  wide response strobe; one cycle; no backpressure.
- wide_r_opc_o  out  1  OR of popped per-port r_opc.
- tcdm_req_o / tcdm_gnt_i  out/in  MP  per-port handshake.
- tcdm_add_o  out  MP×32  wide_add_i + 4·ii, modulo 2^32.
- tcdm_wen_o  out  MP  wide_wen_i broadcast.
- tcdm_be_o  out  MP×4  wide_be_i slice ii.
- tcdm_data_o  out  MP×32  wide_data_i slice ii.
- tcdm_r_data_i / tcdm_r_valid_i / tcdm_r_opc_i  in  MP×32 / MP / MP  per-port responses.
- busy_o  out  1  any transaction granted-partially or outstanding.
- err_o  out  1  sticky: unsolicited narrow response.

## Operation
- Grant mask gmask_q[MP]: bit ii set once port ii has been granted for the current wide request.
- credit_ok = (out_cnt_q < NumOutstanding).
- tcdm_req_o[ii] = wide_req_i & credit_ok & ~gmask_q[ii].
- all_gnt = &(gmask_q | (tcdm_req_o & tcdm_gnt_i)). wide_gnt_o = wide_req_i & credit_ok & all_gnt (combinational, same cycle as final narrow grant). On wide_gnt_o: gmask_q ← 0, else gmask_q ← gmask_q | (tcdm_req_o & tcdm_gnt_i).
- Wide master holds all request fields stable from req until gnt; ports already granted are never re-requested.
- Per-port pend_q[ii] (0..NumOutstanding): +1 on narrow grant, −1 on accepted narrow r_valid; simultaneous → unchanged.
- Narrow r_valid with pend_q[ii]==0: data dropped, err_o ← 1 (cleared only by reset).
- Accepted narrow response (data, opc) pushed into FIFO ii (depth NumOutstanding); cannot overflow due to credit.
- Reads and writes both yield one response per port; write response data ignored but wide_r_valid_o still pulses.
- wide_r_valid_o = &(~fifo_empty); on it, all FIFOs pop once; wide_r_data_o/wide_r_opc_o from FIFO heads.
- out_cnt_q: +1 on wide_gnt_o, −1 on wide_r_valid_o; both → unchanged.
- busy_o = (out_cnt_q ≠ 0) | (|gmask_q).

## Timing
- Reset (rst_i high at a clk_i edge): gmask_q, pend_q, out_cnt_q, FIFOs, err_o cleared. Outputs during/after reset: tcdm_req_o 0 (until wide_req_i), wide_gnt_o 0, wide_r_valid_o 0, wide_r_opc_o 0, wide_r_data_o 0, busy_o 0, err_o 0.
- Reset mid-transaction: partial grants and buffered responses discarded; late narrow responses post-reset flag err_o.
- Grant latency: 0 cycles after the last narrow grant.
- Response latency: wide_r_valid_o 1 cycle after the latest narrow r_valid of that transaction (registered FIFO push, combinational head).
- Back-to-back: with all gnt_i high and out_cnt_q < NumOutstanding, one wide grant per cycle.
- out_cnt_q == NumOutstanding: all tcdm_req_o low; same-cycle wide_r_valid_o does not free credit until next cycle.
- Per-port responses assumed in order within a port; any inter-port skew tolerated.

## Test plan
- MP=8, all gnt_i=1, read at 0x1000_0000 -> wide_gnt_o same cycle, tcdm_add_o[7]=0x1000_001C, responses next cycle -> wide_r_valid_o 1 cycle later, data concatenated correctly.
- Port 3 grant delayed 4 cycles -> only tcdm_req_o[3] stays high cycles 1-4, wide_gnt_o in cycle 4, no port re-requested.
- Port responses skewed (port 0 at t, port 7 at t+5) -> single wide_r_valid_o at t+6, one cycle wide.
- NumOutstanding=2, responses withheld, 3 wide requests -> 2 grants, then tcdm_req_o=0 and busy_o=1 until a wide response.
- Narrow r_valid on port 2 with nothing pending -> err_o=1 sticky, no wide_r_valid_o; rst_i clears it.
- Address 0xFFFF_FFF0, MP=8 -> tcdm_add_o[4]=0x0000_0000 (wrap).
